arith_issue_arbiter: RTL and testbench

Issue arbiter and result sequencer for the shared `arith` execution unit in the out-of-order core. It takes ready-to-issue ALU operations from `NUM_REQ` reservation-station ports and grants one per cycle, round-robin. It drives the `arith` request/operand inputs and captures `writeback_value_o` at the unit's fixed one-cycle latency. It then delivers tagged results through a 2-entry buffer with valid/ready backpressure toward the CDB.

---
 rtl/arith_issue_arbiter_if.sv | 44 ++++
 rtl/arith_issue_arbiter.sv | 124 ++++++++++++
 tb/tb_arith_issue_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arith_issue_arbiter_if.sv
// Purpose : bundles the reservation-station issue ports, the arith unit request/result
//           wires, pipeline flush and the CDB writeback handshake into one interface.
// Ports   : slave = arbiter view (suffixes _i/_o are from the arbiter's side);
//           master = requesters + arith unit + CDB view.
interface arith_issue_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 6
);
   // reservation-station issue ports (port k occupies slice k of each packed bus)
   logic [NUM_REQ-1:0]       req_valid_i;
   logic [NUM_REQ-1:0]       req_ready_o;
   logic [NUM_REQ*32-1:0]    req_inst_i;
   logic [NUM_REQ*32-1:0]    req_pc_i;
   logic [NUM_REQ*32-1:0]    req_rs1_i;
   logic [NUM_REQ*32-1:0]    req_rs2_i;
   logic [NUM_REQ*TAG_W-1:0] req_tag_i;
   // shared arith execution unit
   logic                     arith_request_o;
   logic [31:0]              arith_inst_o;
   logic [31:0]              arith_pc_o;
   logic [31:0]              arith_rs1_o;
   logic [31:0]              arith_rs2_o;
   logic [31:0]              arith_result_i;
   // pipeline control and CDB writeback
   logic                     flush_i;
   logic                     wb_valid_o;
   logic                     wb_ready_i;
   logic [TAG_W-1:0]         wb_tag_o;
   logic [31:0]              wb_value_o;

   modport slave (
      input  req_valid_i, req_inst_i, req_pc_i, req_rs1_i, req_rs2_i, req_tag_i,
      input  arith_result_i, flush_i, wb_ready_i,
      output req_ready_o, arith_request_o, arith_inst_o, arith_pc_o, arith_rs1_o,
      output arith_rs2_o, wb_valid_o, wb_tag_o, wb_value_o
   );

   modport master (
      output req_valid_i, req_inst_i, req_pc_i, req_rs1_i, req_rs2_i, req_tag_i,
      output arith_result_i, flush_i, wb_ready_i,
      input  req_ready_o, arith_request_o, arith_inst_o, arith_pc_o, arith_rs1_o,
      input  arith_rs2_o, wb_valid_o, wb_tag_o, wb_value_o
   );
endinterface

// File: rtl/arith_issue_arbiter.sv
// Purpose : round-robin issue arbiter for the shared arith unit plus a 2-entry tagged
//           result buffer toward the CDB. Ports: clk_i, reset_ni, bus (slave modport).
// Latency : grant in cycle N, result sampled in N+1, wb_valid_o from N+2.
// Backpr. : wb_ready_i low stalls the buffer; grants stop once in-flight + buffered
//           results would reach 2, since the arith unit itself cannot stall.
module arith_issue_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 6
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   arith_issue_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] r_rr_ptr;
   logic             r_inflight_v;
   logic [TAG_W-1:0] r_inflight_tag;
   logic [TAG_W-1:0] r_fifo_tag [2];
   logic [31:0]      r_fifo_val [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;

   logic             w_pop;
   logic             w_push;
   logic [2:0]       w_occ;
   logic             w_issue_ok;
   logic             w_found;
   logic             w_grant;
   logic [PTR_W-1:0] w_scan;
   logic [PTR_W-1:0] w_winner;
   logic [PTR_W-1:0] w_rr_next;
   logic [TAG_W-1:0] w_win_tag;

   assign w_pop  = (r_count != 2'd0) && bus.wb_ready_i;
   // a flush kills the result arriving this cycle
   assign w_push = r_inflight_v && !bus.flush_i;

   // occupancy after this cycle's pop, counting the result still inside the unit;
   // issuing only below 2 means a fixed-latency result always finds a free slot
   assign w_occ      = {1'b0, r_count} + {2'b00, r_inflight_v} - {2'b00, w_pop};
   // gated by reset so every output reads 0 the moment reset asserts
   assign w_issue_ok = reset_ni && !bus.flush_i && (w_occ < 3'd2);

   // first valid port scanning upward from r_rr_ptr with wrap
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_scan   = r_rr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && bus.req_valid_i[w_scan]) begin
            w_found  = 1'b1;
            w_winner = w_scan;
         end
         w_scan = (w_scan == PTR_W'(NUM_REQ - 1)) ? '0 : w_scan + PTR_W'(1);
      end
   end

   assign w_grant   = w_issue_ok && w_found;
   assign w_rr_next = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);
   assign w_win_tag = bus.req_tag_i[TAG_W*w_winner +: TAG_W];

   always_comb begin
      bus.req_ready_o = '0;
      if (w_grant) begin
         bus.req_ready_o[w_winner] = 1'b1;
      end
   end

   assign bus.arith_request_o = w_grant;
   assign bus.arith_inst_o    = w_grant ? bus.req_inst_i[32*w_winner +: 32] : 32'd0;
   assign bus.arith_pc_o      = w_grant ? bus.req_pc_i[32*w_winner +: 32]   : 32'd0;
   assign bus.arith_rs1_o     = w_grant ? bus.req_rs1_i[32*w_winner +: 32]  : 32'd0;
   assign bus.arith_rs2_o     = w_grant ? bus.req_rs2_i[32*w_winner +: 32]  : 32'd0;

   assign bus.wb_valid_o = (r_count != 2'd0);
   assign bus.wb_tag_o   = bus.wb_valid_o ? r_fifo_tag[r_rd_ptr] : '0;
   assign bus.wb_value_o = bus.wb_valid_o ? r_fifo_val[r_rd_ptr] : 32'd0;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_rr_ptr       <= '0;
         r_inflight_v   <= 1'b0;
         r_inflight_tag <= '0;
         r_fifo_tag[0]  <= '0;
         r_fifo_tag[1]  <= '0;
         r_fifo_val[0]  <= 32'd0;
         r_fifo_val[1]  <= 32'd0;
         r_wr_ptr       <= 1'b0;
         r_rd_ptr       <= 1'b0;
         r_count        <= 2'd0;
      end else begin
         r_inflight_v <= w_grant;
         if (w_grant) begin
            r_rr_ptr       <= w_rr_next;
            r_inflight_tag <= w_win_tag;
         end
         if (bus.flush_i) begin
            // rr pointer survives a flush; buffered results do not
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
         end else begin
            if (w_push) begin
               r_fifo_tag[r_wr_ptr] <= r_inflight_tag;
               r_fifo_val[r_wr_ptr] <= bus.arith_result_i;
               r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
               r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 2'd1;
               2'b01:   r_count <= r_count - 2'd1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_ni)
      !(w_push && !w_pop && (r_count == 2'd2)));
endmodule

// File: tb/tb_arith_issue_arbiter.sv
module tb_arith_issue_arbiter;
   localparam logic [31:0] ADD_OP  = 32'h00208133;
   localparam logic [31:0] ADDI_OP = 32'h00518093;
   localparam logic [31:0] SUB_OP  = 32'h40208133;

   logic clk_i    = 1'b0;
   logic reset_ni = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   arith_issue_arbiter_if #(.NUM_REQ(4), .TAG_W(6)) bus ();

   arith_issue_arbiter #(.NUM_REQ(4), .TAG_W(6)) dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .bus      (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   // behavioural arith unit: one-cycle latency, garbage when nothing was issued
   function automatic logic [31:0] alu(input logic [31:0] inst, input logic [31:0] a,
                                       input logic [31:0] b);
      logic [31:0] imm;
      imm = {{20{inst[31]}}, inst[31:20]};
      if (inst[6:0] == 7'h13) return a + imm;
      if (inst[30]) return a - b;
      return a + b;
   endfunction

   initial bus.arith_result_i = 32'd0;
   always @(posedge clk_i) begin
      if (bus.arith_request_o)
         bus.arith_result_i <= alu(bus.arith_inst_o, bus.arith_rs1_o, bus.arith_rs2_o);
      else
         bus.arith_result_i <= 32'hDEAD_BEEF;
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_port(input int k, input logic [31:0] inst, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [5:0] tag);
      bus.req_inst_i[32*k +: 32] = inst;
      bus.req_pc_i[32*k +: 32]   = pc;
      bus.req_rs1_i[32*k +: 32]  = rs1;
      bus.req_rs2_i[32*k +: 32]  = rs2;
      bus.req_tag_i[6*k +: 6]    = tag;
   endtask

   task automatic clear_inputs();
      bus.req_valid_i = '0;
      bus.req_inst_i  = '0;
      bus.req_pc_i    = '0;
      bus.req_rs1_i   = '0;
      bus.req_rs2_i   = '0;
      bus.req_tag_i   = '0;
      bus.flush_i     = 1'b0;
      bus.wb_ready_i  = 1'b0;
   endtask

   task automatic do_reset();
      reset_ni = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk_i);
      #1 reset_ni = 1'b1;
   endtask

   task automatic test_reset();
      reset_ni = 1'b0;
      clear_inputs();
      bus.req_valid_i = 4'b1111;
      #3;
      checks++;
      if (bus.req_ready_o !== 4'b0000 || bus.arith_request_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_grant: ready=%b req=%b, want 0000/0", bus.req_ready_o, bus.arith_request_o);
      end
      bus.req_valid_i = 4'b0000;
      step();
      reset_ni = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({bus.wb_valid_o, bus.wb_tag_o, bus.wb_value_o} !== 39'd0) begin
         failures++;
         $display("FAIL reset_wb: valid=%b tag=%0d value=%h, want all 0", bus.wb_valid_o, bus.wb_tag_o, bus.wb_value_o);
      end
      checks++;
      if ({bus.arith_inst_o, bus.arith_pc_o, bus.arith_rs1_o, bus.arith_rs2_o} !== 128'd0) begin
         failures++;
         $display("FAIL reset_operands: inst=%h pc=%h, want 0", bus.arith_inst_o, bus.arith_pc_o);
      end
      step();
   endtask

   task automatic test_single_op();
      do_reset();
      bus.wb_ready_i = 1'b1;
      set_port(0, ADDI_OP, 32'h1000, 32'd2, 32'd0, 6'd5);
      bus.req_valid_i = 4'b0001;
      @(negedge clk_i);
      checks++;
      if (bus.req_ready_o !== 4'b0001 || bus.arith_request_o !== 1'b1) begin
         failures++;
         $display("FAIL single_grant: ready=%b req=%b, want 0001/1", bus.req_ready_o, bus.arith_request_o);
      end
      checks++;
      if (bus.arith_inst_o !== ADDI_OP || bus.arith_pc_o !== 32'h1000 || bus.arith_rs1_o !== 32'd2) begin
         failures++;
         $display("FAIL single_operands: inst=%h pc=%h rs1=%h, want 00518093/1000/2", bus.arith_inst_o, bus.arith_pc_o, bus.arith_rs1_o);
      end
      step();
      bus.req_valid_i = 4'b0000;
      @(negedge clk_i);
      checks++;
      if (bus.wb_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL single_early: wb_valid=%b at N+1, want 0", bus.wb_valid_o);
      end
      step();
      @(negedge clk_i);
      checks++;
      if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 6'd5 || bus.wb_value_o !== 32'd7) begin
         failures++;
         $display("FAIL single_result: valid=%b tag=%0d value=%0d, want 1/5/7", bus.wb_valid_o, bus.wb_tag_o, bus.wb_value_o);
      end
      step();
      @(negedge clk_i);
      checks++;
      if (bus.wb_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL single_pop: wb_valid=%b after pop, want 0", bus.wb_valid_o);
      end
      step();
   endtask

   task automatic test_round_robin();
      do_reset();
      bus.wb_ready_i = 1'b1;
      for (int k = 0; k < 4; k++)
         set_port(k, ADD_OP, 32'(4 * k), 32'(100 * k), 32'(k), 6'(10 + k));
      bus.req_valid_i = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         logic [3:0] exp_rdy;
         int         r;
         exp_rdy = 4'(1 << (c % 4));
         r       = (c - 2) % 4;
         @(negedge clk_i);
         checks++;
         if (bus.req_ready_o !== exp_rdy) begin
            failures++;
            $display("FAIL rr_grant c%0d: ready=%b want %b", c, bus.req_ready_o, exp_rdy);
         end
         if (c >= 2) begin
            checks++;
            if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 6'(10 + r) || bus.wb_value_o !== 32'(101 * r)) begin
               failures++;
               $display("FAIL rr_result c%0d: valid=%b tag=%0d value=%0d want 1/%0d/%0d", c, bus.wb_valid_o, bus.wb_tag_o, bus.wb_value_o, 10 + r, 101 * r);
            end
         end
         step();
      end
      bus.req_valid_i = 4'b0000;
   endtask

   task automatic test_backpressure();
      logic [3:0] exp_rdy [8];
      logic [5:0] exp_tag [8];
      exp_rdy = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
      exp_tag = '{6'd0, 6'd0, 6'd21, 6'd21, 6'd21, 6'd22, 6'd23, 6'd24};
      do_reset();
      set_port(1, ADD_OP, 32'd0, 32'd1, 32'd1, 6'd21);
      set_port(2, ADD_OP, 32'd0, 32'd2, 32'd2, 6'd22);
      bus.req_valid_i = 4'b0110;
      for (int c = 0; c < 9; c++) begin
         // new ops replace granted ones; CDB opens at cycle 4; requests stop at 6
         if (c == 1) set_port(1, ADD_OP, 32'd0, 32'd3, 32'd3, 6'd23);
         if (c == 2) set_port(2, ADD_OP, 32'd0, 32'd4, 32'd4, 6'd24);
         if (c == 4) bus.wb_ready_i = 1'b1;
         if (c == 6) bus.req_valid_i = 4'b0000;
         @(negedge clk_i);
         if (c < 8) begin
            checks++;
            if (bus.req_ready_o !== exp_rdy[c]) begin
               failures++;
               $display("FAIL bp_grant c%0d: ready=%b want %b", c, bus.req_ready_o, exp_rdy[c]);
            end
         end
         if (c >= 2 && c < 8) begin
            checks++;
            if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== exp_tag[c]) begin
               failures++;
               $display("FAIL bp_result c%0d: valid=%b tag=%0d want 1/%0d", c, bus.wb_valid_o, bus.wb_tag_o, exp_tag[c]);
            end
         end
         if (c == 8) begin
            checks++;
            if (bus.wb_valid_o !== 1'b0) begin
               failures++;
               $display("FAIL bp_drained: wb_valid=%b want 0", bus.wb_valid_o);
            end
         end
         step();
      end
   endtask

   task automatic test_push_pop();
      do_reset();
      bus.wb_ready_i = 1'b1;
      for (int c = 0; c < 13; c++) begin
         if (c < 10) begin
            set_port(0, ADD_OP, 32'd0, 32'(c), 32'd1000, 6'(30 + c));
            bus.req_valid_i = 4'b0001;
         end else begin
            bus.req_valid_i = 4'b0000;
         end
         @(negedge clk_i);
         if (c < 10) begin
            checks++;
            if (bus.req_ready_o !== 4'b0001) begin
               failures++;
               $display("FAIL pp_grant c%0d: ready=%b want 0001", c, bus.req_ready_o);
            end
         end
         if (c >= 2 && c < 12) begin
            checks++;
            if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 6'(28 + c) || bus.wb_value_o !== 32'(998 + c)) begin
               failures++;
               $display("FAIL pp_result c%0d: valid=%b tag=%0d value=%0d want 1/%0d/%0d", c, bus.wb_valid_o, bus.wb_tag_o, bus.wb_value_o, 28 + c, 998 + c);
            end
         end
         if (c == 12) begin
            checks++;
            if (bus.wb_valid_o !== 1'b0) begin
               failures++;
               $display("FAIL pp_drained: wb_valid=%b want 0", bus.wb_valid_o);
            end
         end
         step();
      end
   endtask

   task automatic test_flush();
      do_reset();
      bus.wb_ready_i = 1'b1;
      set_port(0, SUB_OP, 32'd0, 32'h10, 32'd5, 6'd7);
      bus.req_valid_i = 4'b0001;
      @(negedge clk_i);
      checks++;
      if (bus.req_ready_o !== 4'b0001 || bus.arith_inst_o !== SUB_OP) begin
         failures++;
         $display("FAIL flush_grant: ready=%b inst=%h want 0001/40208133", bus.req_ready_o, bus.arith_inst_o);
      end
      step();
      set_port(1, ADD_OP, 32'd0, 32'd6, 32'd3, 6'd9);
      bus.req_valid_i = 4'b0010;
      bus.flush_i     = 1'b1;
      @(negedge clk_i);
      checks++;
      if (bus.req_ready_o !== 4'b0000 || bus.arith_request_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_nogrant: ready=%b req=%b want 0000/0", bus.req_ready_o, bus.arith_request_o);
      end
      step();
      bus.flush_i = 1'b0;
      set_port(0, ADD_OP, 32'd0, 32'd1, 32'd1, 6'd8);
      bus.req_valid_i = 4'b0011;
      @(negedge clk_i);
      checks++;
      if (bus.wb_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_killed: wb_valid=%b tag=%0d at N+2 want 0", bus.wb_valid_o, bus.wb_tag_o);
      end
      checks++;
      if (bus.req_ready_o !== 4'b0010) begin
         failures++;
         $display("FAIL flush_rr_kept: ready=%b want 0010", bus.req_ready_o);
      end
      step();
      bus.req_valid_i = 4'b0000;
      @(negedge clk_i);
      checks++;
      if (bus.wb_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_n3: wb_valid=%b want 0", bus.wb_valid_o);
      end
      step();
      @(negedge clk_i);
      checks++;
      if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 6'd9 || bus.wb_value_o !== 32'd9) begin
         failures++;
         $display("FAIL flush_next: valid=%b tag=%0d value=%0d want 1/9/9", bus.wb_valid_o, bus.wb_tag_o, bus.wb_value_o);
      end
      step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_port(0, ADD_OP, 32'd0, 32'd3, 32'd4, 6'd40);
      bus.req_valid_i = 4'b0001;
      @(negedge clk_i);
      checks++;
      if (bus.req_ready_o !== 4'b0001) begin
         failures++;
         $display("FAIL rm_grant0: ready=%b want 0001", bus.req_ready_o);
      end
      step();
      set_port(0, ADD_OP, 32'd0, 32'd5, 32'd6, 6'd41);
      @(negedge clk_i);
      checks++;
      if (bus.req_ready_o !== 4'b0001) begin
         failures++;
         $display("FAIL rm_grant1: ready=%b want 0001", bus.req_ready_o);
      end
      step();
      bus.req_valid_i = 4'b0000;
      @(negedge clk_i);
      checks++;
      if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 6'd40 || bus.wb_value_o !== 32'd7) begin
         failures++;
         $display("FAIL rm_buffered: valid=%b tag=%0d value=%0d want 1/40/7", bus.wb_valid_o, bus.wb_tag_o, bus.wb_value_o);
      end
      step();
      set_port(3, ADD_OP, 32'd0, 32'd1, 32'd1, 6'd50);
      bus.req_valid_i = 4'b1000;
      #2 reset_ni = 1'b0;
      #1;
      checks++;
      if ({bus.req_ready_o, bus.arith_request_o, bus.arith_inst_o, bus.wb_valid_o, bus.wb_tag_o, bus.wb_value_o} !== 76'd0) begin
         failures++;
         $display("FAIL rm_async: ready=%b req=%b valid=%b tag=%0d value=%h want all 0", bus.req_ready_o, bus.arith_request_o, bus.wb_valid_o, bus.wb_tag_o, bus.wb_value_o);
      end
      step();
      reset_ni = 1'b1;
      @(negedge clk_i);
      checks++;
      if (bus.req_ready_o !== 4'b1000 || bus.wb_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL rm_port3: ready=%b valid=%b want 1000/0", bus.req_ready_o, bus.wb_valid_o);
      end
      step();
      bus.req_valid_i = 4'b1011;
      @(negedge clk_i);
      checks++;
      if (bus.req_ready_o !== 4'b0001) begin
         failures++;
         $display("FAIL rm_wrap: ready=%b want 0001", bus.req_ready_o);
      end
      step();
      bus.req_valid_i = 4'b0000;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_op();
      test_round_robin();
      test_backpressure();
      test_push_pop();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
